// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// APB requester that turns single-beat host commands into APB transfers.
// A command is accepted only while the master is idle. It then goes through
// one SETUP cycle and one or more ACCESS cycles. The master returns a
// one-cycle response pulse carrying the read data and an error flag.
// A wait-state timeout aborts the transfer when a slave holds PREADY low for
// too long, so the host cannot be stalled indefinitely.
//
// Parameters
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  max ACCESS cycles with PREADY low before abort (0 = never abort)
//
// Ports
//   PCLK, PRESETn          bus clock (posedge) and async active-low reset
//   cmd_valid/cmd_ready    host command handshake (ready = master idle)
//   cmd_write/addr/wdata   command direction, address and write data
//   rsp_valid              one-cycle pulse when a transfer finishes
//   rsp_rdata, rsp_err     read data and slave-error/timeout flag
//   busy                   high while in SETUP or ACCESS
//   PSEL, PENABLE, PWrite,
//   PADDR, PWDATA          APB request signals (all registered)
//   PREADY, PRDATA,
//   PSLVERR                APB completion signals from the slave
// ---------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,

  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWrite,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  // The counter must hold values up to TIMEOUT-1. It is kept at least one bit
  // wide so that the design still elaborates when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;

  logic               psel_next;
  logic               penable_next;
  logic               pwrite_next;
  logic [ADDR_W-1:0]  paddr_next;
  logic [DATA_W-1:0]  pwdata_next;
  logic               rsp_valid_next;
  logic [DATA_W-1:0]  rsp_rdata_next;
  logic               rsp_err_next;

  // Handshake and status are decoded straight from the state. This means
  // cmd_ready is already high in the cycle that carries the response pulse.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State and all bus/response outputs are registered here. A reset drops
  // the bus immediately and discards any transfer in flight without a
  // response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWrite    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      PSEL      <= psel_next;
      PENABLE   <= penable_next;
      PWrite    <= pwrite_next;
      PADDR     <= paddr_next;
      PWDATA    <= pwdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

  // Next-state and next-output logic. By default every register holds its
  // value. The exception is rsp_valid, which defaults low so that it only
  // pulses for one cycle.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    psel_next      = PSEL;
    penable_next   = PENABLE;
    pwrite_next    = PWrite;
    paddr_next     = PADDR;
    pwdata_next    = PWDATA;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;

    unique case (state)
      IDLE: begin
        // Capture the whole command on the accept edge. PWDATA is captured
        // on reads too, which keeps the datapath free of a direction mux.
        if (cmd_valid) begin
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_wdata;
          psel_next   = 1'b1;
          state_next  = SETUP;
        end
      end

      SETUP: begin
        penable_next  = 1'b1;
        wait_cnt_next = '0;
        state_next    = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = PSLVERR;
          if (!PWrite) begin
            rsp_rdata_next = PRDATA;
          end
          state_next     = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
          // On an abort, the last read data stays visible. Only the error
          // flag tells the host that the transfer did not complete.
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          state_next     = IDLE;
        end else begin
          wait_cnt_next  = wait_cnt + CNT_ONE;
        end
      end

      default: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

endmodule
